// File: rtl/shift_unit.sv
// Iterative shift/rotate unit: moves up to STEP bit positions per clock.
// Requests and results use valid/ready handshakes; only one operation is in flight at a time.
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             op_err,
  output logic             busy
);

  localparam int               RW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WV = WIDTH'(WIDTH);
  localparam logic [RW-1:0]    SV = RW'(STEP);
  localparam logic [RW-1:0]    WR = RW'(WIDTH);

  localparam logic [2:0] OP_SHL = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, stepped;
  logic [2:0]       op_r;
  logic [RW-1:0]    rem, rem_nxt, k, n_eff;
  logic             illegal;

  // Shifts saturate at WIDTH (full b compared); rotates reduce modulo WIDTH.
  always_comb begin
    n_eff   = '0;
    illegal = 1'b0;
    case (op)
      OP_SHL, OP_SHR, OP_SRA: n_eff = (b >= WV) ? WR : RW'(b);
      OP_ROL, OP_ROR:         n_eff = RW'(b % WV);
      default:                illegal = 1'b1;
    endcase
  end

  // One partial step; k is never 0 while BUSY, so rotate complements stay below WIDTH.
  always_comb begin
    k       = (rem > SV) ? SV : rem;
    rem_nxt = rem - k;
    case (op_r)
      OP_SHL:  stepped = acc << k;
      OP_SHR:  stepped = acc >> k;
      OP_SRA:  stepped = $unsigned($signed(acc) >>> k);
      OP_ROL:  stepped = (acc << k) | (acc >> (WR - k));
      OP_ROR:  stepped = (acc >> k) | (acc << (WR - k));
      default: stepped = acc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (n_eff == '0) ? DONE : BUSY;
      BUSY:    if (rem_nxt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      op_r   <= '0;
      rem    <= '0;
      result <= '0;
      op_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          acc  <= a;
          op_r <= op;
          rem  <= n_eff;
          if (n_eff == '0) begin
            result <= a;
            op_err <= illegal;
          end
        end
        BUSY: begin
          acc <= stepped;
          rem <= rem_nxt;
          if (rem_nxt == '0) begin
            result <= stepped;
            op_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_unit.sv
// Directed and randomized checks of shift_unit at WIDTH=32, STEP=4.
module tb_shift_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0, result;
  logic        op_err, busy;
  int          nchk = 0, nfail = 0;

  shift_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .op_err(op_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference: {op_err, result, latency}.
  function automatic logic [39:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] s);
    int n;
    logic [31:0] r;
    logic e;
    e = 1'b0;
    case (o)
      3'd0, 3'd1, 3'd2: n = (s >= 32) ? 32 : int'(s);
      3'd3, 3'd4:       n = int'(s % 32);
      default: begin n = 0; e = 1'b1; end
    endcase
    case (o)
      3'd0: r = (n == 32) ? 32'h0 : x << n;
      3'd1: r = (n == 32) ? 32'h0 : x >> n;
      3'd2: r = (n == 32) ? {32{x[31]}} : $unsigned($signed(x) >>> n);
      3'd3: r = (n == 0) ? x : (x << n) | (x >> (32 - n));
      3'd4: r = (n == 0) ? x : (x >> n) | (x << (32 - n));
      default: r = x;
    endcase
    return {e, r, 7'(1 + (n + 3) / 4)};
  endfunction

  // Issue one request, wait for out_valid; inputs are scrambled after accept.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] s,
                       output logic [31:0] res, output logic err, output int lat);
    @(negedge clk);
    chk("in_ready_before_req", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; a = x; b = s;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'd2; a = 32'hA5A5_5A5A; b = 32'd3;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    err = op_err;
  endtask

  task automatic handshake;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_hs", {29'b0, in_ready, busy, out_valid}, 32'b100);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] s);
    logic [31:0] res;
    logic err;
    int lat;
    logic [39:0] m;
    m = model(o, x, s);
    issue(o, x, s, res, err, lat);
    chk({tag, "_result"}, res, m[38:7]);
    chk({tag, "_op_err"}, {31'b0, err}, {31'b0, m[39]});
    chk({tag, "_latency"}, lat, {25'b0, m[6:0]});
    handshake();
  endtask

  initial begin
    logic [31:0] res;
    logic err;
    int lat;

    #2;
    chk("reset_outs", {result[31:1] != 0, result[0], op_err, out_valid, busy}, 32'b0);
    #20 rst_n = 1'b1;
    #1 chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: SHL by 4
    issue(3'd0, 32'h0000_00F1, 32'd4, res, err, lat);
    chk("shl4_result", res, 32'h0000_0F10);
    chk("shl4_err", {31'b0, err}, 32'd0);
    chk("shl4_lat", lat, 32'd2);
    handshake();

    // 2: SRA saturating at 32
    issue(3'd2, 32'h8000_0000, 32'd35, res, err, lat);
    chk("sra35_result", res, 32'hFFFF_FFFF);
    chk("sra35_lat", lat, 32'd9);
    handshake();

    // 3: rotates by 36 mod 32
    issue(3'd4, 32'h1234_5678, 32'd36, res, err, lat);
    chk("ror36_result", res, 32'h8123_4567);
    chk("ror36_lat", lat, 32'd2);
    handshake();
    issue(3'd3, 32'h1234_5678, 32'd4, res, err, lat);
    chk("rol4_result", res, 32'h2345_6781);
    chk("rol4_lat", lat, 32'd2);
    handshake();

    // 4: zero shift, consumer stalls three cycles
    issue(3'd1, 32'hDEAD_BEEF, 32'd0, res, err, lat);
    chk("shr0_result", res, 32'hDEAD_BEEF);
    chk("shr0_lat", lat, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_result", result, 32'hDEAD_BEEF);
      chk("stall_flags", {29'b0, in_ready, busy, out_valid}, 32'b011);
    end
    handshake();

    // 5: illegal op passes a through and flags error
    issue(3'd7, 32'h5555_AAAA, 32'd7, res, err, lat);
    chk("illegal_result", res, 32'h5555_AAAA);
    chk("illegal_err", {31'b0, err}, 32'd1);
    chk("illegal_lat", lat, 32'd1);
    handshake();

    // 6: reset mid-operation
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; a = 32'd1; b = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_result", result, 32'h0);
    chk("midreset_flags", {29'b0, op_err, busy, out_valid}, 32'b000);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    issue(3'd0, 32'd1, 32'd31, res, err, lat);
    chk("shl31_result", res, 32'h8000_0000);
    chk("shl31_lat", lat, 32'd9);
    handshake();

    // Boundary amounts
    run("shr32", 3'd1, 32'hFFFF_FFFF, 32'd32);
    run("shl_huge", 3'd0, 32'hFFFF_FFFF, 32'h8000_0000);
    run("sra_pos", 3'd2, 32'h7000_0001, 32'd31);
    run("rol32", 3'd3, 32'hCAFE_F00D, 32'd32);
    run("ror31", 3'd4, 32'h0000_0001, 32'd31);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] s;
      s = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
      run("rand", 3'($urandom_range(0, 7)), $urandom, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
